// File: rtl/usb_blk_pkg.sv
// rtl/usb_blk_pkg.sv - shared types and widths for bulk endpoint routing
package usb_blk_pkg;

   localparam int EP_W   = 4;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_IN_ACT    = 2'd1,
      ST_OUT_ACT   = 2'd2,
      ST_OUT_FLUSH = 2'd3
   } state_t;

endpackage

// File: rtl/usb_blk_ep_router_if.sv
// rtl/usb_blk_ep_router_if.sv - bulk IN/OUT port between usb_xfer and the endpoint router
interface usb_blk_ep_router_if;
   import usb_blk_pkg::*;

   logic [EP_W-1:0]   blk_xfer_endpoint_i;
   logic              blk_in_xfer_i;
   logic              blk_out_xfer_i;
   logic              bid_has_data_o;
   logic              bid_tvalid_o;
   logic              bid_tlast_o;
   logic [BYTE_W-1:0] bid_tdata_o;
   logic              bid_tready_i;
   logic              blk_out_ready_read_o;
   logic [BYTE_W-1:0] blk_out_data_i;
   logic              blk_out_valid_i;

   // usb_xfer side
   modport master (
      output blk_xfer_endpoint_i, blk_in_xfer_i, blk_out_xfer_i,
      output bid_tready_i, blk_out_data_i, blk_out_valid_i,
      input  bid_has_data_o, bid_tvalid_o, bid_tlast_o, bid_tdata_o,
      input  blk_out_ready_read_o
   );

   // router side
   modport slave (
      input  blk_xfer_endpoint_i, blk_in_xfer_i, blk_out_xfer_i,
      input  bid_tready_i, blk_out_data_i, blk_out_valid_i,
      output bid_has_data_o, bid_tvalid_o, bid_tlast_o, bid_tdata_o,
      output blk_out_ready_read_o
   );

endinterface

// File: rtl/usb_out_lookahead.sv
// rtl/usb_out_lookahead.sv - one-byte OUT holding stage that marks the final byte with tlast
module usb_out_lookahead
   import usb_blk_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [BYTE_W-1:0] data_i,
   input  logic              flush_i,
   output logic              tvalid_o,
   output logic              tlast_o,
   output logic [BYTE_W-1:0] tdata_o
);

   logic [BYTE_W-1:0] hold_q, hold_d;
   logic              full_q, full_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic [BYTE_W-1:0] tdata_q, tdata_d;

   // A byte is only known not to be the last once its successor arrives or the phase ends
   always_comb begin
      hold_d   = hold_q;
      full_d   = full_q;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tdata_d  = tdata_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (flush_i) begin
         if (full_q) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = hold_q;
         end
         full_d = 1'b0;
      end else if (push_i) begin
         if (full_q) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
         end
         hold_d = data_i;
         full_d = 1'b1;
      end
   end

   // Holding register and registered output strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q   <= '0;
         full_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
      end else begin
         hold_q   <= hold_d;
         full_q   <= full_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
      end
   end

   assign tvalid_o = tvalid_q;
   assign tlast_o  = tlast_q;
   assign tdata_o  = tdata_q;

endmodule

// File: rtl/usb_blk_ep_router.sv
// rtl/usb_blk_ep_router.sv - steers the single bulk IN/OUT port to NUM_EP endpoint channels
module usb_blk_ep_router
   import usb_blk_pkg::*;
#(
   parameter int NUM_EP  = 2,
   parameter int EP_BASE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   usb_blk_ep_router_if.slave       bus,
   input  logic [NUM_EP-1:0]        ch_has_data_i,
   input  logic [NUM_EP-1:0]        ch_in_tvalid_i,
   input  logic [NUM_EP-1:0]        ch_in_tlast_i,
   input  logic [BYTE_W*NUM_EP-1:0] ch_in_tdata_i,
   output logic [NUM_EP-1:0]        ch_in_tready_o,
   input  logic [NUM_EP-1:0]        ch_out_ready_i,
   output logic [NUM_EP-1:0]        ch_out_tvalid_o,
   output logic [NUM_EP-1:0]        ch_out_tlast_o,
   output logic [BYTE_W-1:0]        ch_out_tdata_o,
   input  logic [NUM_EP-1:0]        halt_set_i,
   input  logic [NUM_EP-1:0]        halt_clr_i,
   output logic [NUM_EP-1:0]        halted_o,
   output logic                     ep_err_o
);

   state_t            state_q, state_d;
   logic [EP_W-1:0]   sel_q, sel_d;
   logic              in_lvl_q, out_lvl_q;
   logic              err_q, err_d;
   logic [NUM_EP-1:0] halted_q, halted_d;

   logic [EP_W-1:0]   idx;
   logic              hit;
   logic              rise_in, rise_out;
   logic              tok_has_data, tok_out_ready;
   logic              la_clear, la_push, la_flush;
   logic              la_tvalid, la_tlast;
   logic [BYTE_W-1:0] la_tdata;

   // Below-base endpoints underflow idx, so the lower bound is tested separately
   assign idx      = bus.blk_xfer_endpoint_i - EP_W'(EP_BASE);
   assign hit      = (bus.blk_xfer_endpoint_i >= EP_W'(EP_BASE)) && (idx < EP_W'(NUM_EP));
   assign rise_in  = bus.blk_in_xfer_i & ~in_lvl_q;
   assign rise_out = bus.blk_out_xfer_i & ~out_lvl_q;
   assign halted_d = halt_set_i | (halted_q & ~halt_clr_i);

   // Token-time readiness of the addressed channel, gated by its halt flag
   always_comb begin
      tok_has_data  = 1'b0;
      tok_out_ready = 1'b0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (idx == EP_W'(i)) begin
            tok_has_data  = ch_has_data_i[i] & ~halted_q[i];
            tok_out_ready = ch_out_ready_i[i] & ~halted_q[i];
         end
      end
   end

   assign bus.bid_has_data_o       = hit & tok_has_data;
   assign bus.blk_out_ready_read_o = hit & tok_out_ready;

   // Phase sequencing; IN wins when both levels are high, which is also flagged as an error
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      err_d    = 1'b0;
      la_clear = 1'b0;
      la_push  = 1'b0;
      la_flush = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise_in || rise_out) begin
               if (!hit || (bus.blk_in_xfer_i && bus.blk_out_xfer_i)) begin
                  err_d = 1'b1;
               end
               if (hit && rise_in) begin
                  state_d = ST_IN_ACT;
                  sel_d   = idx;
               end else if (hit && rise_out && !bus.blk_in_xfer_i) begin
                  state_d  = ST_OUT_ACT;
                  sel_d    = idx;
                  la_clear = 1'b1;
               end
            end
         end
         ST_IN_ACT: begin
            if (!bus.blk_in_xfer_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_OUT_ACT: begin
            if (!bus.blk_out_xfer_i) begin
               la_flush = 1'b1;
               state_d  = ST_OUT_FLUSH;
            end else begin
               la_push = bus.blk_out_valid_i;
            end
         end
         ST_OUT_FLUSH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, selected channel, edge history, error pulse and halt flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         in_lvl_q  <= 1'b0;
         out_lvl_q <= 1'b0;
         err_q     <= 1'b0;
         halted_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         in_lvl_q  <= bus.blk_in_xfer_i;
         out_lvl_q <= bus.blk_out_xfer_i;
         err_q     <= err_d;
         halted_q  <= halted_d;
      end
   end

   // IN data is a pure combinational pass-through from the selected channel
   always_comb begin
      bus.bid_tvalid_o = 1'b0;
      bus.bid_tlast_o  = 1'b0;
      bus.bid_tdata_o  = '0;
      ch_in_tready_o   = '0;
      if (state_q == ST_IN_ACT) begin
         for (int i = 0; i < NUM_EP; i++) begin
            if (sel_q == EP_W'(i)) begin
               bus.bid_tvalid_o  = ch_in_tvalid_i[i];
               bus.bid_tlast_o   = ch_in_tlast_i[i];
               bus.bid_tdata_o   = ch_in_tdata_i[i*BYTE_W +: BYTE_W];
               ch_in_tready_o[i] = bus.bid_tready_i;
            end
         end
      end
   end

   usb_out_lookahead u_lookahead (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (la_clear),
      .push_i   (la_push),
      .data_i   (bus.blk_out_data_i),
      .flush_i  (la_flush),
      .tvalid_o (la_tvalid),
      .tlast_o  (la_tlast),
      .tdata_o  (la_tdata)
   );

   // OUT strobes go only to the channel latched at phase start
   always_comb begin
      ch_out_tvalid_o = '0;
      ch_out_tlast_o  = '0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (sel_q == EP_W'(i)) begin
            ch_out_tvalid_o[i] = la_tvalid;
            ch_out_tlast_o[i]  = la_tlast;
         end
      end
   end

   assign ch_out_tdata_o = la_tdata;
   assign halted_o       = halted_q;
   assign ep_err_o       = err_q;

endmodule

// File: tb/tb_usb_blk_ep_router.sv
// tb/tb_usb_blk_ep_router.sv - self-checking bench for usb_blk_ep_router
module tb_usb_blk_ep_router;

   localparam int NUM_EP  = 2;
   localparam int EP_BASE = 1;

   typedef struct {
      int ch;
      int data;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   logic [NUM_EP-1:0]   ch_has_data, ch_in_tvalid, ch_in_tlast, ch_in_tready;
   logic [8*NUM_EP-1:0] ch_in_tdata;
   logic [NUM_EP-1:0]   ch_out_ready, ch_out_tvalid, ch_out_tlast;
   logic [7:0]          ch_out_tdata;
   logic [NUM_EP-1:0]   halt_set, halt_clr, halted;
   logic                ep_err;

   usb_blk_ep_router_if bus ();

   usb_blk_ep_router #(.NUM_EP(NUM_EP), .EP_BASE(EP_BASE)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .ch_has_data_i   (ch_has_data),
      .ch_in_tvalid_i  (ch_in_tvalid),
      .ch_in_tlast_i   (ch_in_tlast),
      .ch_in_tdata_i   (ch_in_tdata),
      .ch_in_tready_o  (ch_in_tready),
      .ch_out_ready_i  (ch_out_ready),
      .ch_out_tvalid_o (ch_out_tvalid),
      .ch_out_tlast_o  (ch_out_tlast),
      .ch_out_tdata_o  (ch_out_tdata),
      .halt_set_i      (halt_set),
      .halt_clr_i      (halt_clr),
      .halted_o        (halted),
      .ep_err_o        (ep_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cnt = 0;

   // model state
   bit         m_halt [NUM_EP];
   bit         m_in_act = 0;
   int         m_in_sel = 0;
   exp_t       exp_q [$];
   logic [8:0] in_got [$];
   int         out_strobes = 0;
   int         err_seen = 0;
   int         tlast_cyc = -1;
   int         tlast_data = -1;
   int         fall_cyc = 0;
   bit         tready0_seen = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cnt <= cnt + 1;

   // Compare process: DUT outputs against the transaction-level model
   always @(negedge clk) begin
      if (!rst) begin
         int   e;
         int   c;
         logic exp_hd;
         logic exp_rr;
         exp_t x;
         e = int'(bus.blk_xfer_endpoint_i);
         c = e - EP_BASE;
         exp_hd = 1'b0;
         exp_rr = 1'b0;
         if (e >= EP_BASE && c < NUM_EP) begin
            exp_hd = ch_has_data[c] && !m_halt[c];
            exp_rr = ch_out_ready[c] && !m_halt[c];
         end
         chk("bid_has_data", bus.bid_has_data_o, exp_hd);
         chk("out_ready_read", bus.blk_out_ready_read_o, exp_rr);
         if (ch_in_tready[0]) tready0_seen = 1;
         if (m_in_act) begin
            chk("bid_tvalid", bus.bid_tvalid_o, ch_in_tvalid[m_in_sel]);
            chk("bid_tlast", bus.bid_tlast_o, ch_in_tlast[m_in_sel]);
            chk("bid_tdata", bus.bid_tdata_o, ch_in_tdata[m_in_sel*8 +: 8]);
            chk("ch_in_tready", ch_in_tready, bus.bid_tready_i ? (1 << m_in_sel) : 0);
            if (bus.bid_tvalid_o && bus.bid_tready_i) in_got.push_back({bus.bid_tlast_o, bus.bid_tdata_o});
         end else begin
            chk("bid_tvalid_idle", bus.bid_tvalid_o, 0);
            chk("ch_in_tready_idle", ch_in_tready, 0);
         end
         if (ch_out_tvalid != 0) begin
            out_strobes++;
            if (exp_q.size() == 0) begin
               chk("out_extra", ch_out_tvalid, 0);
            end else begin
               x = exp_q.pop_front();
               chk("out_ch", ch_out_tvalid, 1 << x.ch);
               chk("out_data", ch_out_tdata, x.data);
               chk("out_last", ch_out_tlast, x.last ? (1 << x.ch) : 0);
               if (ch_out_tlast != 0) begin
                  tlast_cyc  = cnt;
                  tlast_data = int'(ch_out_tdata);
               end
            end
         end else begin
            chk("out_tlast_idle", ch_out_tlast, 0);
         end
         if (ep_err) err_seen++;
      end
   end

   task automatic out_pkt(int ep, int n, int b0, int step);
      int c;
      c = ep - EP_BASE;
      if (ep >= EP_BASE && c < NUM_EP) begin
         for (int k = 0; k < n; k++) exp_q.push_back('{c, (b0 + k*step) & 8'hFF, k == n-1});
      end
      bus.blk_xfer_endpoint_i = 4'(ep);
      bus.blk_out_xfer_i = 1'b1;
      tick(1);
      for (int k = 0; k < n; k++) begin
         bus.blk_out_valid_i = 1'b1;
         bus.blk_out_data_i  = 8'(b0 + k*step);
         tick(1);
         bus.blk_out_valid_i = 1'b0;
         tick(1);
      end
      bus.blk_out_xfer_i = 1'b0;
      fall_cyc = cnt;
      tick(3);
   endtask

   int eps  [5] = '{0, 1, 2, 3, 15};
   int exph [5] = '{0, 1, 1, 0, 0};
   int s0;
   int e0;

   initial begin
      rst = 1'b1;
      ch_has_data = '0; ch_in_tvalid = '0; ch_in_tlast = '0; ch_in_tdata = '0;
      ch_out_ready = '0; halt_set = '0; halt_clr = '0;
      bus.blk_xfer_endpoint_i = '0; bus.blk_in_xfer_i = 1'b0; bus.blk_out_xfer_i = 1'b0;
      bus.bid_tready_i = 1'b0; bus.blk_out_data_i = '0; bus.blk_out_valid_i = 1'b0;
      for (int i = 0; i < NUM_EP; i++) m_halt[i] = 0;
      tick(2);
      chk("rst_out_tvalid", ch_out_tvalid, 0);
      chk("rst_out_tlast", ch_out_tlast, 0);
      chk("rst_out_tdata", ch_out_tdata, 0);
      chk("rst_ep_err", ep_err, 0);
      chk("rst_in_tready", ch_in_tready, 0);
      chk("rst_bid_tvalid", bus.bid_tvalid_o, 0);
      chk("rst_halted", halted, 0);
      rst = 1'b0;
      tick(1);

      // endpoint decode sweep, including below-base and above-range endpoints
      ch_has_data = 2'b11;
      ch_out_ready = 2'b11;
      for (int ep = 0; ep < 16; ep++) begin
         bus.blk_xfer_endpoint_i = 4'(ep);
         tick(1);
      end
      for (int i = 0; i < 5; i++) begin
         bus.blk_xfer_endpoint_i = 4'(eps[i]);
         #1;
         chk("decode_has_data", bus.bid_has_data_o, exph[i]);
         chk("decode_ready_read", bus.blk_out_ready_read_o, exph[i]);
         tick(1);
      end
      ch_has_data = 2'b00;

      // IN on EP2 from channel 1, channel 0 busy with unrelated data
      bus.blk_xfer_endpoint_i = 4'd2;
      bus.blk_in_xfer_i = 1'b1;
      ch_has_data = 2'b10;
      ch_in_tvalid[0] = 1'b1;
      ch_in_tdata[7:0] = 8'h5A;
      tick(1);
      m_in_act = 1; m_in_sel = 1;
      tick(1);
      bus.bid_tready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ch_in_tvalid[1] = 1'b1;
         ch_in_tdata[15:8] = 8'(8'hA0 + i);
         ch_in_tlast[1] = (i == 3);
         tick(1);
      end
      ch_in_tvalid = '0; ch_in_tlast = '0;
      bus.bid_tready_i = 1'b0;
      bus.blk_in_xfer_i = 1'b0;
      tick(1);
      m_in_act = 0;
      tick(1);
      chk("in_count", in_got.size(), 4);
      for (int i = 0; i < 4 && i < in_got.size(); i++)
         chk("in_byte", in_got[i], (i == 3 ? 256 : 0) + 160 + i);
      chk("in_tready0", tready0_seen, 0);

      // OUT on EP1: 0x11, 0x22, 0x33
      s0 = out_strobes;
      out_pkt(1, 3, 8'h11, 8'h11);
      chk("out1_strobes", out_strobes - s0, 3);
      chk("out1_tlast_data", tlast_data, 8'h33);
      chk("out1_tlast_lat", tlast_cyc - fall_cyc, 1);
      chk("out1_drained", exp_q.size(), 0);

      // halt gating on channel 1
      ch_has_data = 2'b10;
      bus.blk_xfer_endpoint_i = 4'd2;
      halt_set[1] = 1'b1;
      tick(1);
      halt_set = '0; m_halt[1] = 1;
      chk("halt_set", halted, 2'b10);
      bus.blk_in_xfer_i = 1'b1;
      tick(1);
      m_in_act = 1; m_in_sel = 1;
      chk("halt_has_data", bus.bid_has_data_o, 0);
      tick(1);
      bus.blk_in_xfer_i = 1'b0;
      tick(1);
      m_in_act = 0;
      halt_clr[1] = 1'b1;
      tick(1);
      halt_clr = '0; m_halt[1] = 0;
      chk("halt_clr_has_data", bus.bid_has_data_o, 1);
      chk("halt_clr", halted, 0);
      halt_set[0] = 1'b1; halt_clr[0] = 1'b1;
      tick(1);
      halt_set = '0; halt_clr = '0; m_halt[0] = 1;
      chk("halt_set_wins", halted, 2'b01);
      halt_clr[0] = 1'b1;
      tick(1);
      halt_clr = '0; m_halt[0] = 0;
      ch_has_data = '0;

      // unmapped endpoints: EP5 IN and EP0 OUT
      e0 = err_seen;
      s0 = out_strobes;
      bus.blk_xfer_endpoint_i = 4'd5;
      bus.blk_in_xfer_i = 1'b1;
      ch_has_data = 2'b11;
      tick(1);
      chk("unmapped_has_data", bus.bid_has_data_o, 0);
      tick(2);
      bus.blk_in_xfer_i = 1'b0;
      ch_has_data = '0;
      tick(2);
      chk("unmapped_err", err_seen - e0, 1);
      out_pkt(0, 2, 8'h70, 1);
      chk("ep0_err", err_seen - e0, 2);
      chk("unmapped_strobes", out_strobes - s0, 0);

      // both levels at once: IN wins, error flagged
      e0 = err_seen;
      bus.blk_xfer_endpoint_i = 4'd1;
      bus.blk_in_xfer_i = 1'b1; bus.blk_out_xfer_i = 1'b1;
      tick(1);
      m_in_act = 1; m_in_sel = 0;
      tick(1);
      bus.blk_in_xfer_i = 1'b0; bus.blk_out_xfer_i = 1'b0;
      tick(1);
      m_in_act = 0;
      tick(1);
      chk("both_err", err_seen - e0, 1);

      // zero-length OUT then an immediate packet two cycles after the fall
      s0 = out_strobes;
      bus.blk_xfer_endpoint_i = 4'd1;
      bus.blk_out_xfer_i = 1'b1;
      tick(1);
      bus.blk_out_xfer_i = 1'b0;
      tick(2);
      chk("zlp_strobes", out_strobes - s0, 0);
      out_pkt(1, 2, 8'h80, 1);
      chk("after_zlp_strobes", out_strobes - s0, 2);
      chk("after_zlp_drained", exp_q.size(), 0);

      // reset after the second OUT byte, then a clean packet
      bus.blk_xfer_endpoint_i = 4'd1;
      bus.blk_out_xfer_i = 1'b1;
      tick(1);
      exp_q.push_back('{0, 8'h91, 1'b0});
      bus.blk_out_valid_i = 1'b1; bus.blk_out_data_i = 8'h91;
      tick(1);
      bus.blk_out_data_i = 8'h92;
      tick(1);
      bus.blk_out_valid_i = 1'b0;
      tick(1);
      chk("pre_rst_drained", exp_q.size(), 0);
      rst = 1'b1;
      #1;
      chk("rst_mid_tvalid", ch_out_tvalid, 0);
      chk("rst_mid_tdata", ch_out_tdata, 0);
      chk("rst_mid_err", ep_err, 0);
      exp_q.delete();
      m_in_act = 0;
      for (int i = 0; i < NUM_EP; i++) m_halt[i] = 0;
      bus.blk_out_xfer_i = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(1);
      s0 = out_strobes;
      out_pkt(1, 3, 8'h44, 8'h11);
      chk("post_rst_strobes", out_strobes - s0, 3);
      chk("post_rst_tlast_data", tlast_data, 8'h66);
      chk("post_rst_drained", exp_q.size(), 0);

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
